// File: rtl/x_seq_pkg.sv
// Shared types and default sizing for the X operand buffer sequencer.
package x_seq_pkg;

    localparam int DEF_X_BYTES    = 32;
    localparam int DEF_N_COLS     = 4;
    localparam int DEF_MAC_CYCLES = 8;
    localparam int DEF_ROM_AW     = 5;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W = cnt_w(DEF_N_COLS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MAC    = 3'd2,
        S_RESULT = 3'd3,
        S_SHIFT  = 3'd4,
        S_DONE   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/x_seq_ctrl_if.sv
// Control/handshake bundle between the sequencer and its environment.
// load_err exists only when X_SEQ_CHECK_EN is defined.
interface x_seq_ctrl_if
    import x_seq_pkg::*;
#(
    parameter int ROM_AW = DEF_ROM_AW
) ();

    logic              start;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic              buf_load_en;
    logic              buf_valid;
    logic              buf_shift;
    logic              xload_done;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic              mac_en;
    logic              mac_clr;
    logic              res_valid;
    logic              res_ready;
    logic [COL_W-1:0]  col_idx;
    logic              busy;
    logic              done;
`ifdef X_SEQ_CHECK_EN
    logic              load_err;
`endif

    modport slave (
        input  start, clr, in_valid, xload_done, res_ready,
        output in_ready, buf_load_en, buf_valid, buf_shift, rom_en, rom_addr,
               mac_en, mac_clr, res_valid, col_idx, busy, done
`ifdef X_SEQ_CHECK_EN
        , output load_err
`endif
    );

    modport master (
        output start, clr, in_valid, xload_done, res_ready,
        input  in_ready, buf_load_en, buf_valid, buf_shift, rom_en, rom_addr,
               mac_en, mac_clr, res_valid, col_idx, busy, done
`ifdef X_SEQ_CHECK_EN
        , input load_err
`endif
    );

endinterface

// File: rtl/x_seq_addr_gen.sv
// MAC-cycle and column counters; derives coefficient ROM address and accumulator clear.
module x_seq_addr_gen
    import x_seq_pkg::*;
#(
    parameter int N_COLS     = DEF_N_COLS,
    parameter int MAC_CYCLES = DEF_MAC_CYCLES,
    parameter int ROM_AW     = DEF_ROM_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              k_step,
    input  logic              col_step,
    input  logic              mac_active,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              mac_clr,
    output logic [COL_W-1:0]  col_cnt,
    output logic              last_k,
    output logic              last_col
);

    localparam int KW = cnt_w(MAC_CYCLES);

    logic [KW-1:0] k_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_cnt   <= '0;
            col_cnt <= '0;
        end else if (clear) begin
            k_cnt   <= '0;
            col_cnt <= '0;
        end else begin
            if (k_step)
                k_cnt <= last_k ? '0 : k_cnt + 1'b1;
            if (col_step)
                col_cnt <= col_cnt + 1'b1;
        end
    end

    assign last_k   = (k_cnt == KW'(MAC_CYCLES - 1));
    assign last_col = (col_cnt == COL_W'(N_COLS - 1));
    assign rom_addr = ROM_AW'(col_cnt) * ROM_AW'(MAC_CYCLES) + ROM_AW'(k_cnt);
    assign mac_clr  = mac_active && (k_cnt == '0);

endmodule

// File: rtl/x_seq_ctrl.sv
// X operand buffer sequencer: byte load, per-column MAC/result/shift, done pulse.
// Define X_SEQ_CHECK_EN to add the sticky load_err consistency check on xload_done.
//
// state  | meaning
// IDLE   | waiting for start, all strobes low
// LOAD   | accepting X_BYTES beats into the X buffer
// MAC    | MAC_CYCLES accumulate cycles with ROM addressing
// RESULT | column result presented until res_ready
// SHIFT  | one-cycle X shift before the next column
// DONE   | one-cycle done pulse
module x_seq_ctrl
    import x_seq_pkg::*;
#(
    parameter int X_BYTES    = DEF_X_BYTES,
    parameter int N_COLS     = DEF_N_COLS,
    parameter int MAC_CYCLES = DEF_MAC_CYCLES,
    parameter int ROM_AW     = DEF_ROM_AW
) (
    input  logic        clk,
    input  logic        rst,
    x_seq_ctrl_if.slave bus
);

    localparam int LW = cnt_w(X_BYTES);

    seq_state_t       state;
    logic [LW-1:0]    load_cnt;
    logic             in_ready_q, load_en_q, shift_q, rom_en_q, mac_en_q;
    logic             res_valid_q, busy_q, done_q;
    logic [COL_W-1:0] col_idx_q;
    logic [COL_W-1:0] col_cnt;
    logic             last_k, last_col, last_beat, cnt_clear;

    assign last_beat = (load_cnt == LW'(X_BYTES - 1));
    assign cnt_clear = bus.clr || (state == S_IDLE) || (state == S_DONE);

    x_seq_addr_gen #(
        .N_COLS     (N_COLS),
        .MAC_CYCLES (MAC_CYCLES),
        .ROM_AW     (ROM_AW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear),
        .k_step     (mac_en_q),
        .col_step   (shift_q),
        .mac_active (mac_en_q),
        .rom_addr   (bus.rom_addr),
        .mac_clr    (bus.mac_clr),
        .col_cnt    (col_cnt),
        .last_k     (last_k),
        .last_col   (last_col)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            load_cnt    <= '0;
            in_ready_q  <= 1'b0;
            load_en_q   <= 1'b0;
            shift_q     <= 1'b0;
            rom_en_q    <= 1'b0;
            mac_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
            col_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (bus.clr) begin
            state       <= S_IDLE;
            load_cnt    <= '0;
            in_ready_q  <= 1'b0;
            load_en_q   <= 1'b0;
            shift_q     <= 1'b0;
            rom_en_q    <= 1'b0;
            mac_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
            col_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            shift_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= S_LOAD;
                        load_cnt   <= '0;
                        in_ready_q <= 1'b1;
                        load_en_q  <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        load_cnt <= load_cnt + 1'b1;
                        if (last_beat) begin
                            state      <= S_MAC;
                            in_ready_q <= 1'b0;
                            load_en_q  <= 1'b0;
                            rom_en_q   <= 1'b1;
                            mac_en_q   <= 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    if (last_k) begin
                        state       <= S_RESULT;
                        rom_en_q    <= 1'b0;
                        mac_en_q    <= 1'b0;
                        res_valid_q <= 1'b1;
                        col_idx_q   <= col_cnt;
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (last_col) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= S_SHIFT;
                            shift_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    state    <= S_MAC;
                    rom_en_q <= 1'b1;
                    mac_en_q <= 1'b1;
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.buf_load_en = load_en_q;
    assign bus.buf_valid   = bus.in_valid & in_ready_q;
    assign bus.buf_shift   = shift_q;
    assign bus.rom_en      = rom_en_q;
    assign bus.mac_en      = mac_en_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.col_idx     = col_idx_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

`ifdef X_SEQ_CHECK_EN
    logic load_err_q, shifted;

    // xload_done must rise exactly on the last load beat and stay low until the first shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_err_q <= 1'b0;
            shifted    <= 1'b0;
        end else if (state == S_IDLE && bus.start && !bus.clr) begin
            load_err_q <= 1'b0;
            shifted    <= 1'b0;
        end else begin
            if (state == S_SHIFT)
                shifted <= 1'b1;
            if (state == S_LOAD && (bus.xload_done != last_beat))
                load_err_q <= 1'b1;
            else if (state != S_LOAD && state != S_IDLE && !shifted && bus.xload_done)
                load_err_q <= 1'b1;
        end
    end

    assign bus.load_err = load_err_q;
`else
    logic unused_xload_done;
    assign unused_xload_done = bus.xload_done;
`endif

endmodule

// File: tb/tb_x_seq_ctrl.sv
// Self-checking bench for x_seq_ctrl: a job-level trace generator predicts every cycle.
module tb_x_seq_ctrl;
    import x_seq_pkg::*;

    localparam int XB = 32;
    localparam int NC = 4;
    localparam int MC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    x_seq_ctrl_if bus ();
    x_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic start; logic clr; logic in_valid; logic res_ready; logic xload_done;
    } stim_t;

    typedef struct packed {
        logic in_ready; logic load_en; logic buf_valid; logic shift; logic rom_en;
        logic [4:0] addr; logic mac_en; logic mac_clr; logic res_valid;
        logic [1:0] col; logic busy; logic done; logic load_err;
    } exp_t;

    stim_t sq[$];
    exp_t  eq[$];
    exp_t  oq[$];
    int    job_start[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  model_err = 1'b0;

    task automatic push(input stim_t s, input exp_t e, input logic set_err);
        e.load_err = model_err;
        sq.push_back(s);
        eq.push_back(e);
        if (s.start && !e.busy && !s.clr) model_err = 1'b0;
        else if (set_err)                 model_err = 1'b1;
    endtask

    task automatic gen_idle(input int n, input int clr_at);
        stim_t s; exp_t e;
        for (int i = 0; i < n; i++) begin
            s = '0; s.in_valid = i[0]; s.res_ready = 1'b1; s.clr = (i == clr_at);
            e = '0;
            push(s, e, 1'b0);
        end
    endtask

    // One job as the outside world sees it: load phase, per-column MAC/result/shift, done.
    task automatic gen_job(input bit toggle, input int stall_col, input int stall_n,
                           input int abort_addr, input int err_beat);
        stim_t s; exp_t e;
        int beats, p, tgt, st;
        beats = 0; p = 0;
        tgt = (err_beat >= 0) ? err_beat : XB - 1;
        job_start.push_back(sq.size());
        s = '0; s.start = 1'b1; s.res_ready = 1'b1; e = '0;
        push(s, e, 1'b0);
        while (beats < XB) begin
            s = '0; s.in_valid = toggle ? (p % 2 == 0) : 1'b1;
            s.start = (p == 5); s.res_ready = 1'b1; s.xload_done = (beats == tgt);
            e = '0; e.in_ready = 1'b1; e.load_en = 1'b1; e.buf_valid = s.in_valid; e.busy = 1'b1;
            push(s, e, s.xload_done != (beats == XB - 1));
            if (s.in_valid) beats++;
            p++;
        end
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < MC; k++) begin
                s = '0; s.in_valid = 1'b1; s.start = (k == 2); s.res_ready = 1'b1;
                s.clr = ((c * MC + k) == abort_addr);
                e = '0; e.rom_en = 1'b1; e.mac_en = 1'b1; e.addr = 5'(c * MC + k);
                e.mac_clr = (k == 0); e.busy = 1'b1;
                push(s, e, 1'b0);
                if (s.clr) return;
            end
            st = (c == stall_col) ? stall_n : 0;
            for (int i = 0; i <= st; i++) begin
                s = '0; s.in_valid = 1'b1; s.res_ready = (i == st);
                e = '0; e.res_valid = 1'b1; e.col = 2'(c); e.busy = 1'b1;
                push(s, e, 1'b0);
            end
            if (c < NC - 1) begin
                s = '0; s.in_valid = 1'b1; s.res_ready = 1'b1;
                e = '0; e.shift = 1'b1; e.busy = 1'b1;
                push(s, e, 1'b0);
            end
        end
        s = '0; s.start = 1'b1; s.res_ready = 1'b1;
        e = '0; e.done = 1'b1; e.busy = 1'b1;
        push(s, e, 1'b0);
    endtask

    function automatic exp_t sample();
        exp_t o;
        o = '0;
        o.in_ready  = bus.in_ready;  o.load_en = bus.buf_load_en; o.buf_valid = bus.buf_valid;
        o.shift     = bus.buf_shift; o.rom_en  = bus.rom_en;      o.addr      = bus.rom_addr;
        o.mac_en    = bus.mac_en;    o.mac_clr = bus.mac_clr;     o.res_valid = bus.res_valid;
        o.col       = bus.col_idx;   o.busy    = bus.busy;        o.done      = bus.done;
`ifdef X_SEQ_CHECK_EN
        o.load_err  = bus.load_err;
`endif
        return o;
    endfunction

    task automatic check_vec(input int cyc, input exp_t e_in, input exp_t o_in);
        exp_t e, o;
        e = e_in; o = o_in;
        if (!e.rom_en)    begin e.addr = '0; o.addr = '0; end
        if (!e.res_valid) begin e.col  = '0; o.col  = '0; end
`ifndef X_SEQ_CHECK_EN
        e.load_err = 1'b0; o.load_err = 1'b0;
`endif
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL outputs cycle %0d: got %b required %b", cyc, o, e);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic drive(input stim_t s);
        bus.start = s.start; bus.clr = s.clr; bus.in_valid = s.in_valid;
        bus.res_ready = s.res_ready; bus.xload_done = s.xload_done;
    endtask

    task automatic scan(input bit mdl, input int s0, input int last,
                        output int nr, output int nv, output int ns,
                        output int fm, output int dn, output int c2);
        exp_t v;
        nr = 0; nv = 0; ns = 0; fm = -1; dn = -1; c2 = 0;
        for (int i = s0; i <= last && i < eq.size(); i++) begin
            v = mdl ? eq[i] : oq[i];
            if (v.in_ready)  nr++;
            if (v.buf_valid) nv++;
            if (v.shift)     ns++;
            if (v.res_valid && v.col == 2'd2) c2++;
            if (v.rom_en && fm < 0) fm = i - s0;
            if (v.done && dn < 0)   dn = i - s0;
        end
    endtask

    initial begin
        exp_t o;
        int nr, nv, ns, fm, dn, c2, s0;

        drive('0);
        #1;
        o = sample();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %b required 0", o);
        end

        gen_idle(3, 1);
        gen_job(1'b0, -1, 0, -1, -1);
        gen_idle(2, -1);
        gen_job(1'b1, 2, 5, -1, -1);
        gen_idle(2, -1);
        gen_job(1'b0, -1, 0, 11, -1);
        gen_idle(2, -1);
        gen_job(1'b0, -1, 0, -1, -1);
`ifdef X_SEQ_CHECK_EN
        gen_idle(1, -1);
        gen_job(1'b0, -1, 0, -1, 10);
        gen_idle(2, -1);
        gen_job(1'b0, -1, 0, -1, -1);
`endif
        gen_idle(3, -1);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < sq.size(); i++) begin
            @(negedge clk);
            drive(sq[i]);
            #1;
            o = sample();
            oq.push_back(o);
            check_vec(i, eq[i], o);
        end

        // Clean job: 32 load cycles, MAC at cycle 33, 3 shifts, done at cycle 72.
        s0 = job_start[0];
        scan(1'b1, s0, s0 + 73, nr, nv, ns, fm, dn, c2);
        chk_int("model_done_cycle", dn, 72);
        chk_int("model_mac_entry", fm, 33);
        scan(1'b0, s0, s0 + 73, nr, nv, ns, fm, dn, c2);
        chk_int("in_ready_cycles", nr, 32);
        chk_int("buf_valid_beats", nv, 32);
        chk_int("mac_entry_cycle", fm, 33);
        chk_int("buf_shift_pulses", ns, 3);
        chk_int("done_cycle", dn, 72);

        // Toggled input and 5-cycle result stall on column 2.
        s0 = job_start[1];
        scan(1'b1, s0, s0 + 109, nr, nv, ns, fm, dn, c2);
        chk_int("model_stall_done", dn, 108);
        scan(1'b0, s0, s0 + 109, nr, nv, ns, fm, dn, c2);
        chk_int("stall_beats", nv, 32);
        chk_int("stall_mac_entry", fm, 64);
        chk_int("col2_res_valid_cycles", c2, 6);
        chk_int("stall_done_cycle", dn, 108);

        // Abort at column 1, k=3.
        s0 = job_start[2];
        chk_int("model_abort_addr", int'(eq[s0 + 46].addr), 11);
        chk_int("abort_rom_addr", int'(oq[s0 + 46].addr), 11);
        chk_int("abort_next_busy", int'(oq[s0 + 47].busy), 0);
        chk_int("abort_next_strobes", int'({oq[s0 + 47].rom_en, oq[s0 + 47].mac_en,
                oq[s0 + 47].res_valid, oq[s0 + 47].in_ready, oq[s0 + 47].shift}), 0);

        s0 = job_start[3];
        scan(1'b0, s0, s0 + 73, nr, nv, ns, fm, dn, c2);
        chk_int("restart_done_cycle", dn, 72);

`ifdef X_SEQ_CHECK_EN
        chk_int("load_err_sticky", int'(oq[job_start[4] + 40].load_err), 1);
        chk_int("load_err_clean", int'(oq[job_start[5] + 5].load_err), 0);
`endif

        // Asynchronous reset in the middle of a load.
        @(negedge clk);
        bus.start = 1'b1; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk_int("busy_before_rst", int'(bus.busy), 1);
        #1;
        rst = 1'b1;
        #1;
        o = sample();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL async_rst: got %b required 0", o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        o = sample();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL post_rst_idle: got %b required 0", o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
